// File: rtl/axi_burst_store_master.sv
// Single-burst AXI-style write initiator: one AW handshake, then len+1 W beats
// streamed straight from the upstream FIFO, then a wait for the B response.
module axi_burst_store_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic [15:0]           din_strb,
  output logic                  axi_awvalid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_awready,
  output logic                  axi_wvalid,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [15:0]           axi_wstrb,
  output logic                  axi_wlast,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           burst_count
);

  localparam int LANE_WIDTH = DATA_WIDTH / 16;
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(15);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              len_reg;
  logic [7:0]              beat_cnt_reg;
  logic                    awvalid_reg;
  logic                    bready_reg;
  logic                    busy_reg;
  logic                    cmd_ready_reg;
  logic                    done_reg;
  logic [15:0]             burst_count_reg;

  logic in_w;
  logic last_beat;
  logic w_fire;

  assign in_w      = (state_reg == W);
  // Compare happens before the increment, so len 255 yields 256 beats without wrapping.
  assign last_beat = (beat_cnt_reg == len_reg);
  assign w_fire    = in_w && din_valid && axi_wready;

  assign cmd_ready   = cmd_ready_reg;
  assign axi_awvalid = awvalid_reg;
  assign axi_awaddr  = addr_reg;
  assign axi_bready  = bready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign burst_count = burst_count_reg;

  // Data channel is a pure pass-through, gated so nothing leaks outside W.
  assign axi_wvalid = in_w && din_valid;
  assign din_ready  = in_w && axi_wready;
  assign axi_wlast  = in_w && last_beat;

  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    assign axi_wdata[gi*LANE_WIDTH +: LANE_WIDTH] =
      in_w ? din_data[gi*LANE_WIDTH +: LANE_WIDTH] : '0;
    assign axi_wstrb[gi] = in_w && din_strb[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      len_reg         <= '0;
      beat_cnt_reg    <= '0;
      awvalid_reg     <= 1'b0;
      bready_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      cmd_ready_reg   <= 1'b1;
      done_reg        <= 1'b0;
      burst_count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            addr_reg      <= cmd_addr & ~BEAT_MASK;
            len_reg       <= cmd_len;
            beat_cnt_reg  <= '0;
            awvalid_reg   <= 1'b1;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= AW;
          end
        end
        AW: begin
          if (axi_awready) begin
            awvalid_reg <= 1'b0;
            state_reg   <= W;
          end
        end
        W: begin
          if (w_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (last_beat) begin
              bready_reg <= 1'b1;
              state_reg  <= B;
            end
          end
        end
        B: begin
          if (axi_bvalid) begin
            bready_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            cmd_ready_reg   <= 1'b1;
            done_reg        <= 1'b1;
            burst_count_reg <= burst_count_reg + 16'd1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_burst_store_master.md
# axi_burst_store_master

AXI-style write initiator for the burst store path: accepts one store command (base address + beat count), issues a single write-address handshake, and streams 128-bit data beats from an upstream FIFO onto the write-data channel with byte strobes and a last-beat marker. It then waits for the write response before accepting the next command. It drives the slave side implemented by the team's AXI memory model (AW/W/B, no length field, 16-byte beat stride).

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 128, beat width; strobe width is fixed at 16
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  store command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_WIDTH  byte base address; low 4 bits ignored
- cmd_len  in  8  beats minus one (0..255 → 1..256 beats)
- din_valid  in  1  data beat valid
- din_ready  out  1  data beat consumed when din_valid && din_ready
- din_data  in  DATA_WIDTH  beat payload
- din_strb  in  16  byte enables for the beat
- axi_awvalid  out  1  write address valid
- axi_awaddr  out  ADDR_WIDTH  16-byte aligned burst base
- axi_awready  in  1  slave address ready
- axi_wvalid  out  1  write data valid
- axi_wdata  out  DATA_WIDTH  write data
- axi_wstrb  out  16  write strobes
- axi_wlast  out  1  last beat of burst
- axi_wready  in  1  slave data ready
- axi_bvalid  in  1  write response valid
- axi_bready  out  1  master response ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after response handshake
- burst_count  out  16  completed bursts, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, AW, W, B.
- IDLE: cmd_ready=1. On cmd handshake: latch addr_q={cmd_addr[ADDR_WIDTH-1:4],4'b0}, len_q=cmd_len, beat_cnt=0; go AW.
- AW: axi_awvalid=1, axi_awaddr=addr_q, held stable until axi_awready. Handshake → W. awvalid never depends on awready.
- W: axi_wvalid=din_valid, axi_wdata=din_data, axi_wstrb=din_strb, din_ready=axi_wready (combinational pass-through, W state only). axi_wlast=(beat_cnt==len_q). Each W handshake: beat_cnt+1; if wlast → B.
- B: axi_bready=1. On axi_bvalid → IDLE, done=1 next cycle, burst_count+1.
- No W beats issued before AW handshake completes.
- Outside W: axi_wvalid=0, din_ready=0, axi_wlast=0. Outside AW: axi_awvalid=0. Outside B: axi_bready=0.
- beat_cnt 8-bit; compare precedes increment so len_q=255 yields exactly 256 beats, no wrap hazard.
- All-zero din_strb beat is legal, counted as a beat.
- cmd_len/cmd_addr changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, axi_awvalid=0, axi_awaddr=0, axi_wvalid=0, axi_wlast=0, axi_bready=0, din_ready=0, done=0, busy=0, burst_count=0; cmd_ready=1 from first non-reset cycle.
- Cmd accepted at edge t → axi_awvalid high in cycle t+1.
- AW handshake at edge t → first beat may transfer in cycle t+1.
- Zero-wait burst of N beats: cmd→B-state entry = N+2 cycles.
- B handshake at edge t → done=1 and cmd_ready=1 in cycle t+1; new cmd accepted at t+1 gives awvalid at t+2.
- din_valid low mid-burst: wvalid drops, beat_cnt holds, wlast holds its value.
- axi_wready low: din_ready low, no beat consumed.
- axi_bvalid outside B ignored.
- rst mid-burst: next cycle all outputs at reset values, partial burst abandoned, burst_count not incremented, no done.

## Test plan
- Single beat: cmd_addr=0x1004, cmd_len=0, one beat 0xA5…A5 strb 0xFFFF → awaddr=0x1000, one W beat with wlast=1, done one cycle after bvalid, memory word at 0x1000 holds data.
- 4-beat burst, awready held low 3 cycles: awaddr stable throughout, no wvalid until AW handshake, wlast only on beat 4, burst_count=1.
- din_valid toggling every other cycle on 8-beat burst with strb 0x00FF: exactly 8 W handshakes, wlast on 8th, upper bytes of memory untouched.
- cmd_len=255: 256 W handshakes, wlast only on the 256th, FSM returns to IDLE, done pulses once.
- Back-to-back commands (cmd_valid held high): second awvalid rises two cycles after first B handshake; cmd_ready low while busy.
- rst asserted on beat 2 of 4: next cycle all outputs at reset values, busy=0, done never pulses, new command then completes normally.
